// File: rtl/rv32i_types.sv
// ============================================================================
// Module      : rv32i_types
// Description : Shared RV32I decode types: opcodes, immediate formats, ibuf entry.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32i_types;

    typedef enum logic [6:0] {
        OPC_LOAD     = 7'b0000011,
        OPC_MISC_MEM = 7'b0001111,
        OPC_OP_IMM   = 7'b0010011,
        OPC_AUIPC    = 7'b0010111,
        OPC_STORE    = 7'b0100011,
        OPC_OP       = 7'b0110011,
        OPC_LUI      = 7'b0110111,
        OPC_BRANCH   = 7'b1100011,
        OPC_JALR     = 7'b1100111,
        OPC_JAL      = 7'b1101111,
        OPC_SYSTEM   = 7'b1110011
    } opcode_t;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_fmt_t;

    // Widest order tag an entry can hold; narrower tags are zero-extended.
    localparam int IBUF_ORDER_W = 64;

    typedef struct packed {
        logic [31:0]             inst;
        logic [31:0]             pc;
        logic [31:0]             pc_next;
        logic [IBUF_ORDER_W-1:0] order;
    } ibuf_entry_t;

    function automatic imm_fmt_t imm_fmt_of(input logic [6:0] opc);
        imm_fmt_t fmt;
        fmt = IMM_NONE;
        if (opc == OPC_LOAD || opc == OPC_OP_IMM || opc == OPC_JALR) fmt = IMM_I;
        else if (opc == OPC_STORE)                                  fmt = IMM_S;
        else if (opc == OPC_BRANCH)                                 fmt = IMM_B;
        else if (opc == OPC_LUI || opc == OPC_AUIPC)                fmt = IMM_U;
        else if (opc == OPC_JAL)                                    fmt = IMM_J;
        return fmt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/id_field_decode.sv
// ============================================================================
// Module      : id_field_decode
// Description : Combinational register-index and immediate extraction.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_field_decode
    import rv32i_types::*;
(
    input  logic [31:0] inst_i,
    output logic [4:0]  rs1_s_o,
    output logic [4:0]  rs2_s_o,
    output logic [4:0]  rd_s_o,
    output logic [31:0] imm_o,
    output logic        uses_rs1_o,
    output logic        uses_rs2_o
);

    logic [6:0] w_opc;
    imm_fmt_t   w_fmt;

    assign w_opc = inst_i[6:0];
    assign w_fmt = imm_fmt_of(w_opc);

    always_comb begin
        uses_rs1_o = !(w_opc == OPC_LUI || w_opc == OPC_AUIPC || w_opc == OPC_JAL);
        uses_rs2_o = (w_opc == OPC_STORE || w_opc == OPC_BRANCH || w_opc == OPC_OP);
    end

    // Unused indices read as x0 so the hazard compare can never match them.
    assign rs1_s_o = uses_rs1_o ? inst_i[19:15] : 5'd0;
    assign rs2_s_o = uses_rs2_o ? inst_i[24:20] : 5'd0;
    assign rd_s_o  = inst_i[11:7];

    always_comb begin
        imm_o = 32'd0;
        case (w_fmt)
            IMM_I:   imm_o = {{20{inst_i[31]}}, inst_i[31:20]};
            IMM_S:   imm_o = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            IMM_B:   imm_o = {{19{inst_i[31]}}, inst_i[31], inst_i[7],
                              inst_i[30:25], inst_i[11:8], 1'b0};
            IMM_U:   imm_o = {inst_i[31:12], 12'd0};
            IMM_J:   imm_o = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12],
                              inst_i[20], inst_i[30:21], 1'b0};
            default: imm_o = 32'd0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/id_ibuf_decode.sv
// ============================================================================
// Module      : id_ibuf_decode
// Description : Instruction buffer with flush, load-use hold and field decode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ibuf_decode
    import rv32i_types::*;
#(
    parameter  int DEPTH   = 4,
    parameter  int ORDER_W = 64,
    localparam int PTR_W   = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               imem_resp,
    input  logic [31:0]        imem_rdata,
    input  logic [31:0]        fetch_pc,
    input  logic [31:0]        fetch_pc_next,
    input  logic [ORDER_W-1:0] fetch_order,
    output logic               fetch_ready,
    input  logic               flush,
    input  logic               ex_ready,
    input  logic [4:0]         ex_rd_s,
    input  logic               ex_is_load,
    output logic               out_valid,
    output logic [31:0]        out_inst,
    output logic [31:0]        out_pc,
    output logic [31:0]        out_pc_next,
    output logic [ORDER_W-1:0] out_order,
    output logic [4:0]         out_rs1_s,
    output logic [4:0]         out_rs2_s,
    output logic [4:0]         out_rd_s,
    output logic [31:0]        out_imm,
    output logic               hazard_stall,
    output logic [PTR_W:0]     count,
    output logic               overflow
);

    logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
    logic           overflow_q, overflow_d;

    ibuf_entry_t    mem_q [DEPTH];
    ibuf_entry_t    head;
    ibuf_entry_t    wr_entry;

    logic           empty, full, push, pop, hazard;
    logic           uses_rs1, uses_rs2;

    assign empty = (rd_ptr_q == wr_ptr_q);
    assign full  = (rd_ptr_q[PTR_W-1:0] == wr_ptr_q[PTR_W-1:0]) &&
                   (rd_ptr_q[PTR_W] != wr_ptr_q[PTR_W]);
    assign count = wr_ptr_q - rd_ptr_q;

    assign head  = mem_q[rd_ptr_q[PTR_W-1:0]];

    id_field_decode u_field_decode (
        .inst_i     (head.inst),
        .rs1_s_o    (out_rs1_s),
        .rs2_s_o    (out_rs2_s),
        .rd_s_o     (out_rd_s),
        .imm_o      (out_imm),
        .uses_rs1_o (uses_rs1),
        .uses_rs2_o (uses_rs2)
    );

    assign hazard = !empty && ex_is_load && (ex_rd_s != 5'd0) &&
                    ((uses_rs1 && out_rs1_s == ex_rd_s) ||
                     (uses_rs2 && out_rs2_s == ex_rd_s));

    assign hazard_stall = hazard && !flush;
    assign out_valid    = !empty && !hazard && !flush;
    assign pop          = out_valid && ex_ready;
    assign fetch_ready  = !full || pop;
    assign push         = imem_resp && !flush && (!full || pop);

    assign out_inst     = head.inst;
    assign out_pc       = head.pc;
    assign out_pc_next  = head.pc_next;
    assign out_order    = head.order[ORDER_W-1:0];
    assign overflow     = overflow_q;

    always_comb begin
        wr_entry                     = '0;
        wr_entry.inst                = imem_rdata;
        wr_entry.pc                  = fetch_pc;
        wr_entry.pc_next             = fetch_pc_next;
        wr_entry.order[ORDER_W-1:0]  = fetch_order;
    end

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        overflow_d = overflow_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        // Flush empties the buffer by catching the read side up; push is already blocked.
        if (flush)    rd_ptr_d = wr_ptr_q;
        else if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        if (imem_resp && full && !pop && !flush) overflow_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) mem_q[wr_ptr_q[PTR_W-1:0]] <= wr_entry;
    end

endmodule

`default_nettype wire

// File: tb/tb_id_ibuf_decode.sv
// ============================================================================
// Module      : tb_id_ibuf_decode
// Description : Directed self-checking bench for id_ibuf_decode (DEPTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_ibuf_decode;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_resp;
    logic [31:0] imem_rdata;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_pc_next;
    logic [63:0] fetch_order;
    logic        fetch_ready;
    logic        flush;
    logic        ex_ready;
    logic [4:0]  ex_rd_s;
    logic        ex_is_load;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [31:0] out_pc_next;
    logic [63:0] out_order;
    logic [4:0]  out_rs1_s;
    logic [4:0]  out_rs2_s;
    logic [4:0]  out_rd_s;
    logic [31:0] out_imm;
    logic        hazard_stall;
    logic [2:0]  count;
    logic        overflow;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    id_ibuf_decode #(.DEPTH(4), .ORDER_W(64)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_resp     (imem_resp),
        .imem_rdata    (imem_rdata),
        .fetch_pc      (fetch_pc),
        .fetch_pc_next (fetch_pc_next),
        .fetch_order   (fetch_order),
        .fetch_ready   (fetch_ready),
        .flush         (flush),
        .ex_ready      (ex_ready),
        .ex_rd_s       (ex_rd_s),
        .ex_is_load    (ex_is_load),
        .out_valid     (out_valid),
        .out_inst      (out_inst),
        .out_pc        (out_pc),
        .out_pc_next   (out_pc_next),
        .out_order     (out_order),
        .out_rs1_s     (out_rs1_s),
        .out_rs2_s     (out_rs2_s),
        .out_rd_s      (out_rd_s),
        .out_imm       (out_imm),
        .hazard_stall  (hazard_stall),
        .count         (count),
        .overflow      (overflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fetch(input logic [31:0] inst, input logic [31:0] pc);
        imem_rdata    = inst;
        fetch_pc      = pc;
        fetch_pc_next = pc + 32'd4;
        fetch_order   = {32'hA5A5_0000, pc};
    endtask

    task automatic push_one(input logic [31:0] inst, input logic [31:0] pc);
        set_fetch(inst, pc);
        imem_resp = 1'b1;
        tick();
        imem_resp = 1'b0;
    endtask

    task automatic pop_one();
        ex_ready = 1'b1;
        tick();
        ex_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
        checks++; if (hazard_stall !== 1'b0) begin failures++; $display("FAIL reset_hazard got=%0b exp=0", hazard_stall); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%0b exp=0", overflow); end
        checks++; if (fetch_ready !== 1'b1) begin failures++; $display("FAIL reset_fetch_ready got=%0b exp=1", fetch_ready); end
    endtask

    task automatic test_fill();
        logic [31:0] exp_inst;
        for (int i = 0; i < 4; i++) begin
            push_one(32'h00100093 + i * 32'h00100000, i * 4);
            if (i == 0) begin
                checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL fill_latency_valid got=%0b exp=1", out_valid); end
            end
        end
        #1;
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL fill_count got=%0d exp=4", count); end
        checks++; if (fetch_ready !== 1'b0) begin failures++; $display("FAIL fill_fetch_ready got=%0b exp=0", fetch_ready); end
        ex_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            exp_inst = 32'h00100093 + i * 32'h00100000;
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL drain_valid[%0d] got=%0b exp=1", i, out_valid); end
            checks++; if (out_pc !== i * 4) begin failures++; $display("FAIL drain_pc[%0d] got=%h exp=%h", i, out_pc, i * 4); end
            checks++; if (out_inst !== exp_inst) begin failures++; $display("FAIL drain_inst[%0d] got=%h exp=%h", i, out_inst, exp_inst); end
            checks++; if (out_pc_next !== i * 4 + 4) begin failures++; $display("FAIL drain_pc_next[%0d] got=%h exp=%h", i, out_pc_next, i * 4 + 4); end
            checks++; if (out_order !== {32'hA5A5_0000, 32'(i * 4)}) begin failures++; $display("FAIL drain_order[%0d] got=%h", i, out_order); end
            checks++; if (out_imm !== 32'(i + 1)) begin failures++; $display("FAIL drain_imm[%0d] got=%h exp=%h", i, out_imm, i + 1); end
            tick();
        end
        ex_ready = 1'b0;
        #1;
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL drain_count got=%0d exp=0", count); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL drain_empty_valid got=%0b exp=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) push_one(32'h00000013, 32'h10 + i * 4);
        set_fetch(32'h00000013, 32'h20);
        imem_resp = 1'b1;
        ex_ready  = 1'b1;
        #1;
        checks++; if (fetch_ready !== 1'b1) begin failures++; $display("FAIL b2b_fetch_ready got=%0b exp=1", fetch_ready); end
        tick();
        imem_resp = 1'b0;
        ex_ready  = 1'b0;
        #1;
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL b2b_count got=%0d exp=4", count); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL b2b_overflow got=%0b exp=0", overflow); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_pc !== 32'h14 + i * 4) begin failures++; $display("FAIL b2b_pc[%0d] got=%h exp=%h", i, out_pc, 32'h14 + i * 4); end
            pop_one();
        end
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL b2b_end_count got=%0d exp=0", count); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 4; i++) push_one(32'h00000013, 32'h30 + i * 4);
        push_one(32'h00000013, 32'h40);
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got=%0b exp=1", overflow); end
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL ovf_count got=%0d exp=4", count); end
        checks++; if (out_pc !== 32'h30) begin failures++; $display("FAIL ovf_head_pc got=%h exp=30", out_pc); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL ovf_flush_count got=%0d exp=0", count); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%0b exp=1", overflow); end
        do_reset();
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_rst_clear got=%0b exp=0", overflow); end
    endtask

    task automatic test_load_use();
        push_one(32'h00208133, 32'h50);
        ex_is_load = 1'b1;
        ex_rd_s    = 5'd1;
        ex_ready   = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL lu_rs1_valid got=%0b exp=0", out_valid); end
        checks++; if (hazard_stall !== 1'b1) begin failures++; $display("FAIL lu_rs1_hazard got=%0b exp=1", hazard_stall); end
        checks++; if (out_rs1_s !== 5'd1 || out_rs2_s !== 5'd2 || out_rd_s !== 5'd2) begin
            failures++; $display("FAIL lu_fields got=%0d/%0d/%0d exp=1/2/2", out_rs1_s, out_rs2_s, out_rd_s); end
        tick();
        checks++; if (count !== 3'd1) begin failures++; $display("FAIL lu_hold_count got=%0d exp=1", count); end
        ex_rd_s = 5'd2;
        #1;
        checks++; if (hazard_stall !== 1'b1) begin failures++; $display("FAIL lu_rs2_hazard got=%0b exp=1", hazard_stall); end
        flush = 1'b1;
        #1;
        checks++; if (hazard_stall !== 1'b0) begin failures++; $display("FAIL lu_flush_mask got=%0b exp=0", hazard_stall); end
        flush   = 1'b0;
        ex_rd_s = 5'd0;
        #1;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL lu_x0_valid got=%0b exp=1", out_valid); end
        checks++; if (hazard_stall !== 1'b0) begin failures++; $display("FAIL lu_x0_hazard got=%0b exp=0", hazard_stall); end
        tick();
        ex_ready   = 1'b0;
        ex_is_load = 1'b0;
        #1;
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL lu_pop_count got=%0d exp=0", count); end
    endtask

    task automatic test_flush_push();
        for (int i = 0; i < 3; i++) push_one(32'h00000013, 32'h60 + i * 4);
        checks++; if (count !== 3'd3) begin failures++; $display("FAIL fl_pre_count got=%0d exp=3", count); end
        set_fetch(32'h00000013, 32'h99);
        flush     = 1'b1;
        imem_resp = 1'b1;
        ex_ready  = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL fl_valid got=%0b exp=0", out_valid); end
        tick();
        flush     = 1'b0;
        imem_resp = 1'b0;
        ex_ready  = 1'b0;
        #1;
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL fl_count got=%0d exp=0", count); end
        tick();
        checks++; if (out_valid !== 1'b0 || count !== 3'd0) begin
            failures++; $display("FAIL fl_push_dropped valid=%0b count=%0d exp=0/0", out_valid, count); end
    endtask

    task automatic test_imm();
        push_one(32'hFE112E23, 32'h70);
        checks++; if (out_imm !== 32'hFFFFFFFC) begin failures++; $display("FAIL imm_s got=%h exp=FFFFFFFC", out_imm); end
        checks++; if (out_rs1_s !== 5'd2 || out_rs2_s !== 5'd1) begin
            failures++; $display("FAIL imm_s_regs got=%0d/%0d exp=2/1", out_rs1_s, out_rs2_s); end
        pop_one();
        push_one(32'h123450B7, 32'h74);
        checks++; if (out_imm !== 32'h12345000) begin failures++; $display("FAIL imm_u got=%h exp=12345000", out_imm); end
        checks++; if (out_rs1_s !== 5'd0 || out_rs2_s !== 5'd0 || out_rd_s !== 5'd1) begin
            failures++; $display("FAIL imm_u_regs got=%0d/%0d/%0d exp=0/0/1", out_rs1_s, out_rs2_s, out_rd_s); end
        pop_one();
        push_one(32'hFE000CE3, 32'h78);
        checks++; if (out_imm !== 32'hFFFFFFF8) begin failures++; $display("FAIL imm_b got=%h exp=FFFFFFF8", out_imm); end
        pop_one();
        push_one(32'h008000EF, 32'h7C);
        checks++; if (out_imm !== 32'h00000008) begin failures++; $display("FAIL imm_j got=%h exp=00000008", out_imm); end
        pop_one();
        push_one(32'hFFFFFFFF, 32'h80);
        checks++; if (out_imm !== 32'h0 || out_rs1_s !== 5'd31 || out_rs2_s !== 5'd0) begin
            failures++; $display("FAIL imm_none got=%h/%0d/%0d exp=0/31/0", out_imm, out_rs1_s, out_rs2_s); end
        pop_one();
    endtask

    initial begin
        rst           = 1'b1;
        imem_resp     = 1'b0;
        imem_rdata    = 32'd0;
        fetch_pc      = 32'd0;
        fetch_pc_next = 32'd0;
        fetch_order   = 64'd0;
        flush         = 1'b0;
        ex_ready      = 1'b0;
        ex_rd_s       = 5'd0;
        ex_is_load    = 1'b0;
        test_reset();
        test_fill();
        test_back_to_back();
        test_overflow();
        test_load_use();
        test_flush_push();
        test_imm();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
